// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared constants and types for the ALU sequencer.
//             The optional immediate operand is enabled by ALU_SEQ_IMM_EN.
//  Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

  // ALU function-select encodings
  localparam logic [1:0] FS_ADD = 2'b00;
  localparam logic [1:0] FS_CMP = 2'b01;
  localparam logic [1:0] FS_SUB = 2'b10;
  localparam logic [1:0] FS_INC = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Instruction field positions (least significant bit of each field)
  localparam int INSTR_W     = 18;
  localparam int FS_LSB      = 16;
  localparam int RD_LSB      = 14;
  localparam int RA_LSB      = 12;
  localparam int RB_LSB      = 10;
  localparam int IMM_SEL_BIT = 9;
  localparam int IMM_LSB     = 0;

  // Status register bit indices
  localparam int STAT_C = 0;
  localparam int STAT_V = 3;

  // ALU flag bits that the sequencer samples
  localparam int FLAG_C = 0;
  localparam int FLAG_V = 3;

endpackage
`default_nettype wire

// File: rtl/alu_seq_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_regfile
//  Purpose  : 4x8 register file with two operand read ports, a debug read
//             port, and a write path where EXEC writeback overrides a host
//             write to the same register in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ra_addr,
  output logic [7:0] ra_data,
  input  logic [1:0] rb_addr,
  output logic [7:0] rb_data,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data,
  input  logic       wb_en,
  input  logic [1:0] wb_addr,
  input  logic [7:0] wb_data,
  input  logic       host_we,
  input  logic [1:0] host_waddr,
  input  logic [7:0] host_wdata
);

  logic [7:0] r_regs [0:3];

  // Storage update: the writeback assignment comes last so it wins on a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      if (host_we) begin
        r_regs[host_waddr] <= host_wdata;
      end
      if (wb_en) begin
        r_regs[wb_addr] <= wb_data;
      end
    end
  end

  assign ra_data  = r_regs[ra_addr];
  assign rb_data  = r_regs[rb_addr];
  assign dbg_data = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Accepts one instruction per handshake, drives the external ALU
//             for one EXEC cycle, writes the result back, keeps a status
//             register and returns the result on a response channel.
//             Define ALU_SEQ_IMM_EN to allow an 8-bit immediate as operand B.
//  Revision : 1.0  initial release
// ============================================================================
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic [3:0]         status,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [1:0]         alu_fs,
  input  logic [7:0]         alu_c,
  input  logic [7:0]         alu_flag,
  input  logic               host_we,
  input  logic [1:0]         host_waddr,
  input  logic [7:0]         host_wdata,
  input  logic [1:0]         dbg_raddr,
  output logic [7:0]         dbg_rdata
);

  state_t     r_state;
  logic [1:0] r_fs;
  logic [1:0] r_rd;
  logic [1:0] r_ra;
  logic [1:0] r_rb;
`ifdef ALU_SEQ_IMM_EN
  logic       r_imm_sel;
  logic [7:0] r_imm;
`endif
  logic       r_in_ready;
  logic       r_out_valid;
  logic [7:0] r_out_data;
  logic [3:0] r_status;

  logic [7:0] w_ra_data;
  logic [7:0] w_rb_data;
  logic       w_wb_en;
  logic [3:0] w_status_next;
  logic       w_unused;

  // Compare produces no result, so it never writes back
  assign w_wb_en = (r_state == EXEC) && (r_fs != FS_CMP);

  alu_seq_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .ra_addr    (r_ra),
    .ra_data    (w_ra_data),
    .rb_addr    (r_rb),
    .rb_data    (w_rb_data),
    .dbg_addr   (dbg_raddr),
    .dbg_data   (dbg_rdata),
    .wb_en      (w_wb_en),
    .wb_addr    (r_rd),
    .wb_data    (alu_c),
    .host_we    (host_we),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata)
  );

  // ALU operands come straight from the latched fields, so they hold for all of EXEC
  assign alu_a  = w_ra_data;
`ifdef ALU_SEQ_IMM_EN
  assign alu_b  = r_imm_sel ? r_imm : w_rb_data;
  assign w_unused = ^{in_instr[8], alu_flag[7:4], alu_flag[2:1]};
`else
  assign alu_b  = w_rb_data;
  assign w_unused = ^{in_instr[9:0], alu_flag[7:4], alu_flag[2:1]};
`endif
  assign alu_fs = r_fs;

  // Next status: only flag bits 0 and 3 are sampled; bits 2:1 stay zero
  always_comb begin
    w_status_next      = r_status;
    w_status_next[2:1] = 2'b00;
    case (r_fs)
      FS_ADD: begin
        w_status_next[STAT_C] = alu_flag[FLAG_C];
        w_status_next[STAT_V] = 1'b0;
      end
      FS_CMP: begin
        w_status_next[STAT_V] = alu_flag[FLAG_V];
        w_status_next[STAT_C] = 1'b0;
      end
      default: begin
        w_status_next[STAT_V] = alu_flag[FLAG_V];
      end
    endcase
  end

  // Sequencer FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_fs        <= 2'b00;
      r_rd        <= 2'b00;
      r_ra        <= 2'b00;
      r_rb        <= 2'b00;
`ifdef ALU_SEQ_IMM_EN
      r_imm_sel   <= 1'b0;
      r_imm       <= 8'h00;
`endif
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_status    <= 4'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_fs       <= in_instr[FS_LSB +: 2];
            r_rd       <= in_instr[RD_LSB +: 2];
            r_ra       <= in_instr[RA_LSB +: 2];
            r_rb       <= in_instr[RB_LSB +: 2];
`ifdef ALU_SEQ_IMM_EN
            r_imm_sel  <= in_instr[IMM_SEL_BIT];
            r_imm      <= in_instr[IMM_LSB +: 8];
`endif
            r_in_ready <= 1'b0;
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          r_out_data  <= (r_fs == FS_CMP) ? 8'h00 : alu_c;
          r_status    <= w_status_next;
          r_out_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign status    = r_status;

endmodule
`default_nettype wire
